// File: rtl/vga_fb_pkg.sv
// Shared definitions for the VGA framebuffer arbiter: RAM grant encoding,
// screen/framebuffer geometry and the framebuffer address helper.
package vga_fb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DISP = 2'd1,
        GNT_WR   = 2'd2
    } grant_t;

    localparam int SCREEN_X_C = 640;
    localparam int SCREEN_Y_C = 480;
    localparam int H_LAST_C   = 800;
    localparam int V_LAST_C   = 525;
    localparam int FB_W_C     = 160;
    localparam int FB_H_C     = 120;
    localparam int DW_C       = 12;
    localparam int AW_C       = 15;

    localparam int ROW_W_C = 7;   // framebuffer row index, 0..119
    localparam int COL_W_C = 8;   // framebuffer column index, 0..159

    // Row-major address for the 160-column buffer: row*160 = row*128 + row*32.
    function automatic logic [AW_C-1:0] fbAddr(input logic [ROW_W_C-1:0] row,
                                               input logic [COL_W_C-1:0] col);
        logic [AW_C-1:0] rowWide;
        rowWide = {{(AW_C - ROW_W_C){1'b0}}, row};
        fbAddr  = (rowWide << 3'd7) + (rowWide << 3'd5) + {{(AW_C - COL_W_C){1'b0}}, col};
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO holding queued framebuffer writes ({addr, data}).
// DEPTH must be a power of two so the pointers wrap naturally.
module fb_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store_r [DEPTH];
    logic [PW-1:0]    wrPtr_r;
    logic [PW-1:0]    rdPtr_r;
    logic [PW:0]      count_r;
    logic             doPush_s;
    logic             doPop_s;

    assign full     = (count_r == (PW + 1)'(DEPTH));
    assign empty    = (count_r == {(PW + 1){1'b0}});
    assign doPush_s = push && !full;
    assign doPop_s  = pop && !empty;
    assign headData = store_r[rdPtr_r];

    // Entry storage; written only on an accepted push, contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (doPush_s) begin
            store_r[wrPtr_r] <= pushData;
        end
    end

    // Pointers and occupancy; a push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_r <= {PW{1'b0}};
            rdPtr_r <= {PW{1'b0}};
            count_r <= {(PW + 1){1'b0}};
        end else begin
            if (doPush_s) begin
                wrPtr_r <= wrPtr_r + PW'(1);
            end
            if (doPop_s) begin
                rdPtr_r <= rdPtr_r + PW'(1);
            end
            case ({doPush_s, doPop_s})
                2'b10:   count_r <= count_r + (PW + 1)'(1);
                2'b01:   count_r <= count_r - (PW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between the VGA scan-out (absolute
// priority, one fetch per 4 screen pixels) and a queued pixel writer.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int SCREEN_X = SCREEN_X_C,
    parameter int SCREEN_Y = SCREEN_Y_C,
    parameter int H_LAST   = H_LAST_C,
    parameter int V_LAST   = V_LAST_C,
    parameter int FB_W     = FB_W_C,
    parameter int FB_H     = FB_H_C,
    parameter int DW       = DW_C,
    parameter int AW       = AW_C
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    posX,
    input  logic [9:0]    posY,
    output logic [DW-1:0] pixel_out,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          wr_err
);

    logic [10:0]      posXAhead_s;
    logic [9:0]       nextRow_s;
    logic             lineSlot_s;
    logic             wrapSlot_s;
    logic [AW-1:0]    dispAddr_s;
    grant_t           grant_s;
    logic             activeArea_s;

    logic             fifoPush_s;
    logic             fifoPop_s;
    logic             fifoFull_s;
    logic             fifoEmpty_s;
    logic [AW+DW-1:0] fifoHead_s;
    logic [AW-1:0]    headAddr_s;
    logic [DW-1:0]    headData_s;
    logic             headInRange_s;

    logic             readyEn_r;
    logic             slotD1_r;
    logic             wrErr_r;
    logic [DW-1:0]    pixel_r;

    // Fetch two pixels ahead so the word lands in pixel_r exactly at posX%4==0.
    assign posXAhead_s = {1'b0, posX} + 11'd2;
    assign lineSlot_s  = (posX[1:0] == 2'b10) && (posXAhead_s < 11'(SCREEN_X)) &&
                         (posY < 10'(SCREEN_Y));
    assign wrapSlot_s  = (posX == 10'(H_LAST - 1)) && (nextRow_s < 10'(SCREEN_Y));

    assign headAddr_s    = fifoHead_s[AW+DW-1:DW];
    assign headData_s    = fifoHead_s[DW-1:0];
    assign headInRange_s = (headAddr_s < AW'(FB_W * FB_H));

    assign wr_ready   = readyEn_r && !fifoFull_s;
    assign fifoPush_s = wr_valid && wr_ready;
    assign fifoPop_s  = (grant_s == GNT_WR);
    assign wr_err     = wrErr_r;

    fb_wr_fifo #(
        .DEPTH (4),
        .WIDTH (AW + DW)
    ) uWrFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifoPush_s),
        .pushData ({wr_addr, wr_data}),
        .pop      (fifoPop_s),
        .headData (fifoHead_s),
        .full     (fifoFull_s),
        .empty    (fifoEmpty_s)
    );

    // Row whose column 0 is fetched at line end; the last line(s) of the frame roll over to row 0.
    always_comb begin
        if (posY >= 10'(V_LAST - 1)) begin
            nextRow_s = 10'd0;
        end else begin
            nextRow_s = posY + 10'd1;
        end
    end

    // Display fetch address: in-line column ahead, or column 0 of the upcoming row.
    always_comb begin
        if (lineSlot_s) begin
            dispAddr_s = fbAddr(posY[8:2], posXAhead_s[9:2]);
        end else begin
            dispAddr_s = fbAddr(nextRow_s[8:2], 8'd0);
        end
    end

    // Port grant: display slots always win, the writer takes any other cycle with queued data.
    always_comb begin
        if (rst) begin
            grant_s = GNT_NONE;
        end else if (lineSlot_s || wrapSlot_s) begin
            grant_s = GNT_DISP;
        end else if (!fifoEmpty_s) begin
            grant_s = GNT_WR;
        end else begin
            grant_s = GNT_NONE;
        end
    end

    // RAM port drive; an out-of-range head is popped but never reaches the RAM.
    always_comb begin
        mem_addr  = {AW{1'b0}};
        mem_we    = 1'b0;
        mem_wdata = {DW{1'b0}};
        case (grant_s)
            GNT_DISP: begin
                mem_addr = dispAddr_s;
            end
            GNT_WR: begin
                if (headInRange_s) begin
                    mem_addr  = headAddr_s;
                    mem_we    = 1'b1;
                    mem_wdata = headData_s;
                end else begin
                    mem_we = 1'b0;
                end
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // Writer acceptance is held off through reset and enabled on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readyEn_r <= 1'b0;
        end else begin
            readyEn_r <= 1'b1;
        end
    end

    // Sticky flag for dropped out-of-range writes, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrErr_r <= 1'b0;
        end else if ((grant_s == GNT_WR) && !headInRange_s) begin
            wrErr_r <= 1'b1;
        end else begin
            wrErr_r <= wrErr_r;
        end
    end

    // Display pipeline: mark the cycle after a fetch, then capture the RAM word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slotD1_r <= 1'b0;
            pixel_r  <= {DW{1'b0}};
        end else begin
            slotD1_r <= (grant_s == GNT_DISP);
            if (slotD1_r) begin
                pixel_r <= mem_rdata;
            end else begin
                pixel_r <= pixel_r;
            end
        end
    end

    // Blank outside the visible area.
    always_comb begin
        activeArea_s = (posX < 10'(SCREEN_X)) && (posY < 10'(SCREEN_Y));
        if (activeArea_s) begin
            pixel_out = pixel_r;
        end else begin
            pixel_out = {DW{1'b0}};
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed testbench for vga_fb_arbiter with a synchronous single-port RAM model.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  posX;
    logic [9:0]  posY;
    logic [11:0] pixel_out;
    logic        wr_valid;
    logic        wr_ready;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;
    logic        wr_err;

    int checks = 0;
    int errors = 0;

    logic [11:0] ram [0:32767];

    vga_fb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .posX      (posX),
        .posY      (posY),
        .pixel_out (pixel_out),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .wr_err    (wr_err)
    );

    always #5 clk = ~clk;

    // RAM model: read data valid one cycle after its address; write on mem_we.
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; posX = 10'd2; posY = 10'd0;
        wr_valid = 1'b0; wr_addr = 15'd0; wr_data = 12'd0;
        cyc(); cyc(); #3;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready got %b want 0", wr_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
        checks++; if (mem_addr !== 15'd0) begin errors++; $display("FAIL rst_mem_addr got %0d want 0", mem_addr); end
        checks++; if (mem_wdata !== 12'd0) begin errors++; $display("FAIL rst_mem_wdata got %0h want 0", mem_wdata); end
        checks++; if (pixel_out !== 12'd0) begin errors++; $display("FAIL rst_pixel got %0h want 0", pixel_out); end
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL rst_wr_err got %b want 0", wr_err); end
        cyc(); rst = 1'b0; posX = 10'd0; #3;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b want 0", wr_ready); end
        cyc(); #3;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge got %b want 1", wr_ready); end
    endtask

    task automatic test_sweep();
        int expAddr;
        int expPix;
        // End of row 3 fetches framebuffer row 1 column 0, shown from posX=0 of row 4.
        cyc(); posY = 10'd3; posX = 10'd799; #3;
        checks++; if (mem_addr !== 15'd160 || mem_we !== 1'b0) begin errors++; $display("FAIL wrap_row3 got addr %0d we %b want 160 0", mem_addr, mem_we); end
        cyc(); posX = 10'd800; #3;
        checks++; if (pixel_out !== 12'd0) begin errors++; $display("FAIL blank_800 got %0d want 0", pixel_out); end
        posY = 10'd4;
        for (int x = 0; x < 4; x++) begin
            cyc(); posX = 10'(x); #3;
            checks++; if (pixel_out !== 12'd160) begin errors++; $display("FAIL row4_col0 x=%0d got %0d want 160", x, pixel_out); end
        end
        // Final line of the frame prefetches row 0 column 0.
        cyc(); posY = 10'd525; posX = 10'd799; #3;
        checks++; if (mem_addr !== 15'd0 || mem_we !== 1'b0 || pixel_out !== 12'd0) begin errors++; $display("FAIL wrap_525 got addr %0d we %b pix %0d want 0 0 0", mem_addr, mem_we, pixel_out); end
        cyc(); posX = 10'd800; #3;
        posY = 10'd0;
        for (int x = 0; x <= 800; x++) begin
            cyc(); posX = 10'(x); #3;
            if ((x % 4 == 2) && (x + 2 < 640)) expAddr = (x + 2) / 4;
            else expAddr = 0;
            expPix = (x < 640) ? (x / 4) : 0;
            checks++; if (mem_addr !== 15'(expAddr) || mem_we !== 1'b0) begin errors++; $display("FAIL sweep_addr x=%0d got %0d we %b want %0d 0", x, mem_addr, mem_we, expAddr); end
            checks++; if (pixel_out !== 12'(expPix)) begin errors++; $display("FAIL sweep_pixel x=%0d got %0d want %0d", x, pixel_out, expPix); end
        end
    endtask

    task automatic test_slot_edges();
        // A queued write reveals whether the display took the port in a given cycle.
        cyc(); posY = 10'd524; posX = 10'd799; wr_valid = 1'b1; wr_addr = 15'd100; wr_data = 12'hABC; #3;
        checks++; if (mem_addr !== 15'd0 || mem_we !== 1'b0) begin errors++; $display("FAIL wrap_524 got addr %0d we %b want 0 0", mem_addr, mem_we); end
        cyc(); wr_valid = 1'b0; #3;
        checks++; if (mem_addr !== 15'd0 || mem_we !== 1'b0) begin errors++; $display("FAIL wrap_524_holds got addr %0d we %b want 0 0", mem_addr, mem_we); end
        cyc(); posY = 10'd479; #3;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 15'd100 || mem_wdata !== 12'hABC) begin errors++; $display("FAIL no_read_479 got we %b addr %0d data %0h want 1 100 abc", mem_we, mem_addr, mem_wdata); end
        cyc(); #3;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 15'd0) begin errors++; $display("FAIL idle_479 got we %b addr %0d want 0 0", mem_we, mem_addr); end
        cyc(); posY = 10'd0; posX = 10'd634; wr_valid = 1'b1; wr_addr = 15'd102; wr_data = 12'h055; #3;
        checks++; if (mem_addr !== 15'd159 || mem_we !== 1'b0) begin errors++; $display("FAIL slot_634 got addr %0d we %b want 159 0", mem_addr, mem_we); end
        cyc(); wr_valid = 1'b0; #3;
        checks++; if (mem_addr !== 15'd159 || mem_we !== 1'b0) begin errors++; $display("FAIL slot_634_holds got addr %0d we %b want 159 0", mem_addr, mem_we); end
        cyc(); posX = 10'd638; #3;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 15'd102 || mem_wdata !== 12'h055) begin errors++; $display("FAIL no_read_638 got we %b addr %0d data %0h want 1 102 55", mem_we, mem_addr, mem_wdata); end
        cyc(); posX = 10'd3; #3;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL idle_after_638 got we %b want 0", mem_we); end
    endtask

    task automatic test_burst();
        int cnt = 0;
        int idx = 0;
        int wcount = 0;
        bit slot;
        bit expWe;
        bit push;
        posY = 10'd0;
        for (int k = 0; k < 24; k++) begin
            cyc();
            posX = 10'(k);
            wr_valid = (idx < 8);
            wr_addr = 15'(1000 + idx);
            wr_data = 12'(256 + idx);
            #3;
            slot = (k % 4 == 2);
            expWe = !slot && (cnt > 0);
            checks++; if (wr_ready !== 1'(cnt < 4)) begin errors++; $display("FAIL burst_ready k=%0d got %b want %b", k, wr_ready, (cnt < 4)); end
            checks++; if (mem_we !== expWe) begin errors++; $display("FAIL burst_we k=%0d got %b want %b", k, mem_we, expWe); end
            if (mem_we === 1'b1) begin
                checks++; if (mem_addr !== 15'(1000 + wcount) || mem_wdata !== 12'(256 + wcount)) begin errors++; $display("FAIL burst_order k=%0d got %0d/%0h want %0d/%0h", k, mem_addr, mem_wdata, 1000 + wcount, 256 + wcount); end
                wcount++;
            end
            push = wr_valid && (cnt < 4);
            cnt = cnt + (push ? 1 : 0) - (expWe ? 1 : 0);
            if (push) idx++;
        end
        wr_valid = 1'b0;
        checks++; if (wcount != 8) begin errors++; $display("FAIL burst_count got %0d want 8", wcount); end
    endtask

    task automatic test_fifo_full();
        posY = 10'd0;
        // posX held on a slot column: the display owns every cycle and the queue fills.
        for (int k = 0; k < 6; k++) begin
            cyc(); posX = 10'd2; wr_valid = 1'b1; wr_addr = 15'(2000 + k); wr_data = 12'(512 + k); #3;
            checks++; if (wr_ready !== 1'(k < 4)) begin errors++; $display("FAIL fill_ready k=%0d got %b want %b", k, wr_ready, (k < 4)); end
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fill_we k=%0d got %b want 0", k, mem_we); end
        end
        // Drain, with one push landing in the same cycle as a pop.
        for (int k = 0; k < 7; k++) begin
            cyc(); posX = 10'd3; wr_valid = (k == 1); wr_addr = 15'd2004; wr_data = 12'd516; #3;
            checks++; if (wr_ready !== 1'(k != 0)) begin errors++; $display("FAIL drain_ready k=%0d got %b want %b", k, wr_ready, (k != 0)); end
            if (k < 5) begin
                checks++; if (mem_we !== 1'b1 || mem_addr !== 15'(2000 + k) || mem_wdata !== 12'(512 + k)) begin errors++; $display("FAIL drain_write k=%0d got %b %0d/%0d want 1 %0d/%0d", k, mem_we, mem_addr, mem_wdata, 2000 + k, 512 + k); end
            end else begin
                checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL drain_idle k=%0d got %b want 0", k, mem_we); end
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_bad_addr();
        cyc(); posY = 10'd0; posX = 10'd3; wr_valid = 1'b1; wr_addr = 15'd19200; wr_data = 12'd5; #3;
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL err_before got %b want 0", wr_err); end
        cyc(); wr_addr = 15'd19199; wr_data = 12'd7; #3;
        checks++; if (mem_we !== 1'b0 || wr_err !== 1'b0) begin errors++; $display("FAIL bad_dropped got we %b err %b want 0 0", mem_we, wr_err); end
        cyc(); wr_valid = 1'b0; #3;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 15'd19199 || mem_wdata !== 12'd7) begin errors++; $display("FAIL last_addr_write got %b %0d/%0d want 1 19199/7", mem_we, mem_addr, mem_wdata); end
        checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", wr_err); end
        for (int k = 0; k < 4; k++) begin
            cyc(); #3;
            checks++; if (wr_err !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL err_sticky k=%0d got err %b we %b want 1 0", k, wr_err, mem_we); end
        end
    endtask

    task automatic test_reset_midburst();
        posY = 10'd0;
        for (int k = 0; k < 3; k++) begin
            cyc(); posX = 10'd2; wr_valid = 1'b1; wr_addr = 15'(3000 + k); wr_data = 12'(k); #3;
            checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL queue_ready k=%0d got %b want 1", k, wr_ready); end
        end
        cyc(); wr_valid = 1'b0; rst = 1'b1; #3;
        checks++; if (wr_ready !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL midrst_immediate got ready %b we %b want 0 0", wr_ready, mem_we); end
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL midrst_err got %b want 0", wr_err); end
        cyc(); posX = 10'd3; #3;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 15'd0) begin errors++; $display("FAIL midrst_port got we %b addr %0d want 0 0", mem_we, mem_addr); end
        cyc(); rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #3;
            checks++; if (mem_we !== 1'b0 || mem_addr !== 15'd0) begin errors++; $display("FAIL stale_write k=%0d got we %b addr %0d want 0 0", k, mem_we, mem_addr); end
            cyc();
        end
        #3;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ready_after_midrst got %b want 1", wr_ready); end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = 12'(i);
        test_reset();
        test_sweep();
        test_slot_edges();
        test_burst();
        test_fifo_full();
        test_bad_addr();
        test_reset_midburst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
